// File: rtl/qr_stream_pkg.sv
// Shared types and defaults for the QR core front/back-end streamer.
package qr_stream_pkg;

    localparam int unsigned DEF_ROWS       = 8;
    localparam int unsigned DEF_D_WIDTH    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 20;

    typedef enum logic [2:0] {
        LOAD,
        CORE_RST,
        SEND,
        WAIT,
        DRAIN
    } qr_state_e;

    typedef logic signed [DEF_DATA_WIDTH*DEF_D_WIDTH-1:0] qr_row_t;

endpackage

// File: rtl/qr_row_buf.sv
// Row buffer: one synchronous write port, one combinational read port.
module qr_row_buf
    import qr_stream_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned W    = DEF_DATA_WIDTH * DEF_D_WIDTH,
    localparam int unsigned AW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [ROWS];

    // Store one row per write strobe; contents need no reset because
    // validity is tracked by the owner's index counters.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed row.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/qr_matrix_streamer.sv
// Buffers an input matrix, sequences the QR core (reset, gapless row feed),
// captures its unthrottled result rows and releases them downstream.
module qr_matrix_streamer
    import qr_stream_pkg::*;
#(
    parameter int unsigned D_WIDTH    = DEF_D_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [DATA_WIDTH*D_WIDTH-1:0] ld_row,
    output logic                          qr_rst_n,
    output logic                          qr_valid,
    output logic [DATA_WIDTH*D_WIDTH-1:0] qr_a_ij,
    input  logic                          qr_valid_o,
    input  logic [DATA_WIDTH*D_WIDTH-1:0] qr_out_r,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_WIDTH*D_WIDTH-1:0] res_row,
    output logic                          res_last,
    output logic                          busy,
    output logic                          err
);

    localparam int unsigned RW = DATA_WIDTH * D_WIDTH;
    localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    qr_state_e     state_q, state_d;
    logic [IW-1:0] ld_idx, snd_idx, cap_idx, rd_idx;
    logic [TW-1:0] tmo_cnt;
    logic          ld_fire, cap_fire, res_fire, tmo_hit;
    logic [IW-1:0] in_raddr;
    logic [RW-1:0] in_rdata, out_rdata;

    assign ld_fire  = (state_q == LOAD)  && ld_valid;
    assign cap_fire = (state_q == WAIT)  && qr_valid_o;
    assign res_fire = (state_q == DRAIN) && res_ready;
    assign tmo_hit  = (state_q == WAIT) && (tmo_cnt == TMO_LAST)
                      && !(cap_fire && (cap_idx == LAST_IDX));

    // The core-facing outputs are registered, so the in_buf is read one row
    // ahead: row 0 during CORE_RST, row k+1 while row k is on the bus.
    assign in_raddr = (state_q == SEND) ? idx_inc(snd_idx) : '0;

    qr_row_buf #(.ROWS(ROWS), .W(RW)) in_buf (
        .clk   (clk),
        .we    (ld_fire),
        .waddr (ld_idx),
        .wdata (ld_row),
        .raddr (in_raddr),
        .rdata (in_rdata)
    );

    qr_row_buf #(.ROWS(ROWS), .W(RW)) out_buf (
        .clk   (clk),
        .we    (cap_fire),
        .waddr (cap_idx),
        .wdata (qr_out_r),
        .raddr (rd_idx),
        .rdata (out_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake-side outputs.
    always_comb begin
        state_d   = state_q;
        ld_ready  = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        res_last  = 1'b0;
        res_row   = '0;
        case (state_q)
            LOAD: begin
                ld_ready = 1'b1;
                busy     = 1'b0;
                if (ld_fire && (ld_idx == LAST_IDX)) state_d = CORE_RST;
            end
            CORE_RST: state_d = SEND;
            SEND: begin
                if (snd_idx == LAST_IDX) state_d = WAIT;
            end
            WAIT: begin
                if (cap_fire && (cap_idx == LAST_IDX)) state_d = DRAIN;
                else if (tmo_hit)                      state_d = LOAD;
            end
            DRAIN: begin
                res_valid = 1'b1;
                res_row   = out_rdata;
                res_last  = (rd_idx == LAST_IDX);
                if (res_fire && (rd_idx == LAST_IDX)) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // Index counters, timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_idx  <= '0;
            snd_idx <= '0;
            cap_idx <= '0;
            rd_idx  <= '0;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (ld_fire) ld_idx <= idx_inc(ld_idx);

            if (state_q == CORE_RST)  snd_idx <= '0;
            else if (state_q == SEND) snd_idx <= idx_inc(snd_idx);

            if (tmo_hit)       cap_idx <= '0;
            else if (cap_fire) cap_idx <= idx_inc(cap_idx);

            if (res_fire) rd_idx <= idx_inc(rd_idx);

            if (state_q == SEND)      tmo_cnt <= '0;
            else if (state_q == WAIT) tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit || (qr_valid_o && (state_q != WAIT))) err <= 1'b1;
        end
    end

    // Registered core-facing outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            qr_rst_n <= 1'b0;
            qr_valid <= 1'b0;
            qr_a_ij  <= '0;
        end else begin
            qr_rst_n <= (state_d != CORE_RST);
            qr_valid <= (state_d == SEND);
            qr_a_ij  <= (state_d == SEND) ? in_rdata : '0;
        end
    end

endmodule
